mmio_gpio: RTL and testbench

- Parametrised memory-mapped GPIO peripheral on the CPU data bus. Successor to the fixed 16-bit switch read port.
- Adds a writable LED register, synchronised and debounced switch and button inputs, latched button-edge flags with W1C clear, and a maskable interrupt.
- Sits beside data memory and decodes its own word-address window.

---
 rtl/mmio_gpio.sv | 170 +++++++++++++++++
 tb/tb_mmio_gpio.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_gpio.sv
// mmio_gpio: bus-mapped LEDs, debounced switches/buttons, W1C edge flags, irq.
// Define GPIO_FALLING_EDGE_EN to add EDGE_SEL (offset 5) for falling-edge capture.
module mmio_gpio #(
  parameter int ADDR_W          = 30,
  parameter int BASE_ADDR       = 0,
  parameter int LED_W           = 16,
  parameter int SW_W            = 16,
  parameter int BTN_W           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] memAddress,
  input  logic [31:0]       writeData,
  input  logic              writeEnable,
  input  logic              readEnable,
  input  logic [SW_W-1:0]   switches,
  input  logic [BTN_W-1:0]  btns,
  output logic [31:0]       readData,
  output logic [LED_W-1:0]  leds,
  output logic              irq
);
  localparam int CNT_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] BASE_V = ADDR_W'(BASE_ADDR);

  logic [SW_W-1:0]  sw_s1_q, sw_s2_q, sw_stb_q, sw_stb_d;
  logic [BTN_W-1:0] btn_s1_q, btn_s2_q, btn_stb_q, btn_stb_d;
  logic [CNT_W-1:0] sw_cnt_q [SW_W];
  logic [CNT_W-1:0] sw_cnt_d [SW_W];
  logic [CNT_W-1:0] btn_cnt_q [BTN_W];
  logic [CNT_W-1:0] btn_cnt_d [BTN_W];

  logic [LED_W-1:0] led_q, led_d;
  logic [BTN_W-1:0] pend_q, pend_d;
  logic [BTN_W-1:0] mask_q, mask_d;
  logic [BTN_W-1:0] pend_set, pend_clr;
  logic [31:0]      rdata_q, rdata_d, rmux;
  logic             irq_q, irq_d;
  logic             sel, we;
  logic [2:0]       off;
  logic             unused_wd;
`ifdef GPIO_FALLING_EDGE_EN
  logic [BTN_W-1:0] esel_q, esel_d;
`endif

  assign sel = memAddress[ADDR_W-1:3] == BASE_V[ADDR_W-4:0];
  assign off = memAddress[2:0];
  assign we  = writeEnable & sel;
  assign unused_wd = ^writeData;

  assign readData = rdata_q;
  assign leds     = led_q;
  assign irq      = irq_q;

  // debounce: stable follows sync after DEBOUNCE_CYCLES disagreeing cycles
  always_comb begin
    for (int i = 0; i < SW_W; i++) begin
      sw_cnt_d[i] = '0;
      sw_stb_d[i] = sw_stb_q[i];
      if (sw_s2_q[i] != sw_stb_q[i]) begin
        if (sw_cnt_q[i] == CNT_LAST) sw_stb_d[i] = sw_s2_q[i];
        else sw_cnt_d[i] = sw_cnt_q[i] + CNT_ONE;
      end
    end
    for (int i = 0; i < BTN_W; i++) begin
      btn_cnt_d[i] = '0;
      btn_stb_d[i] = btn_stb_q[i];
      if (btn_s2_q[i] != btn_stb_q[i]) begin
        if (btn_cnt_q[i] == CNT_LAST) btn_stb_d[i] = btn_s2_q[i];
        else btn_cnt_d[i] = btn_cnt_q[i] + CNT_ONE;
      end
    end
  end

  // edge capture on the debounced buttons
  always_comb begin
    pend_set = ~btn_stb_q & btn_stb_d;
`ifdef GPIO_FALLING_EDGE_EN
    pend_set = (~esel_q & pend_set) |
               (esel_q & btn_stb_q & ~btn_stb_d);
`endif
  end

  // register writes, W1C with set priority, irq
  always_comb begin
    led_d    = led_q;
    mask_d   = mask_q;
    pend_clr = '0;
`ifdef GPIO_FALLING_EDGE_EN
    esel_d   = esel_q;
`endif
    if (we) begin
      case (off)
        3'd0: led_d = writeData[LED_W-1:0];
        3'd3: pend_clr = writeData[BTN_W-1:0];
        3'd4: mask_d = writeData[BTN_W-1:0];
`ifdef GPIO_FALLING_EDGE_EN
        3'd5: esel_d = writeData[BTN_W-1:0];
`endif
        default: ;
      endcase
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;
    irq_d  = |(pend_q & mask_q);
  end

  // read mux over pre-edge register values
  always_comb begin
    rmux = '0;
    case (off)
      3'd0: rmux[LED_W-1:0] = led_q;
      3'd1: rmux[SW_W-1:0]  = sw_stb_q;
      3'd2: rmux[BTN_W-1:0] = btn_stb_q;
      3'd3: rmux[BTN_W-1:0] = pend_q;
      3'd4: rmux[BTN_W-1:0] = mask_q;
`ifdef GPIO_FALLING_EDGE_EN
      3'd5: rmux[BTN_W-1:0] = esel_q;
`endif
      default: rmux = '0;
    endcase
    rdata_d = rdata_q;
    if (readEnable) rdata_d = sel ? rmux : '0;
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_stb_q  <= '0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      btn_stb_q <= '0;
      for (int i = 0; i < SW_W; i++) sw_cnt_q[i] <= '0;
      for (int i = 0; i < BTN_W; i++) btn_cnt_q[i] <= '0;
      led_q     <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      sw_s1_q   <= switches;
      sw_s2_q   <= sw_s1_q;
      sw_stb_q  <= sw_stb_d;
      btn_s1_q  <= btns;
      btn_s2_q  <= btn_s1_q;
      btn_stb_q <= btn_stb_d;
      for (int i = 0; i < SW_W; i++) sw_cnt_q[i] <= sw_cnt_d[i];
      for (int i = 0; i < BTN_W; i++) btn_cnt_q[i] <= btn_cnt_d[i];
      led_q     <= led_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

`ifdef GPIO_FALLING_EDGE_EN
  // edge select register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) esel_q <= '0;
    else     esel_q <= esel_d;
  end
`endif

endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: scoreboard bench for mmio_gpio with a behavioural model.
// Reads queue an expected value; a negedge monitor pops and compares.
module tb_mmio_gpio;
  localparam int AW   = 30;
  localparam int BASE = 16;
  localparam int LW   = 16;
  localparam int SWW  = 16;
  localparam int BW   = 16;
  localparam int DB   = 4;
  localparam logic [AW-1:0] WIN = AW'(BASE * 8);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] memAddress = '0;
  logic [31:0]   writeData = '0;
  logic          writeEnable = 1'b0;
  logic          readEnable = 1'b0;
  logic [SWW-1:0] switches = '0;
  logic [BW-1:0] btns = '0;
  logic [31:0]   readData;
  logic [LW-1:0] leds;
  logic          irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_gpio #(
    .ADDR_W(AW), .BASE_ADDR(BASE), .LED_W(LW),
    .SW_W(SWW), .BTN_W(BW), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .memAddress(memAddress),
    .writeData(writeData), .writeEnable(writeEnable),
    .readEnable(readEnable), .switches(switches), .btns(btns),
    .readData(readData), .leds(leds), .irq(irq)
  );

  // behavioural model
  logic [LW-1:0]  m_led = '0;
  logic [SWW-1:0] m_sw = '0;
  logic [BW-1:0]  m_btn = '0;
  logic [BW-1:0]  m_pend = '0;
  logic [BW-1:0]  m_mask = '0;
  logic           m_irq = 1'b0;
`ifdef GPIO_FALLING_EDGE_EN
  logic [BW-1:0]  m_esel = '0;
`endif
  logic [SWW-1:0] sw_seen1 = '0, sw_seen2 = '0;
  logic [BW-1:0]  bt_seen1 = '0, bt_seen2 = '0;
  int             sw_run [SWW];
  int             bt_run [BW];
  logic [31:0]    exp_q [$];
  logic           rd_fire = 1'b0;
  logic           hit;
  logic [2:0]     moff;
  logic [BW-1:0]  old_btn, m_set, m_clr;

  function automatic logic [31:0] reg_val(input logic [2:0] o);
    logic [31:0] v;
    v = 32'h0;
    case (o)
      3'd0: v = 32'(m_led);
      3'd1: v = 32'(m_sw);
      3'd2: v = 32'(m_btn);
      3'd3: v = 32'(m_pend);
      3'd4: v = 32'(m_mask);
`ifdef GPIO_FALLING_EDGE_EN
      3'd5: v = 32'(m_esel);
`endif
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_led = '0; m_sw = '0; m_btn = '0;
      m_pend = '0; m_mask = '0; m_irq = 1'b0;
`ifdef GPIO_FALLING_EDGE_EN
      m_esel = '0;
`endif
      sw_seen1 = '0; sw_seen2 = '0;
      bt_seen1 = '0; bt_seen2 = '0;
      for (int i = 0; i < SWW; i++) sw_run[i] = 0;
      for (int i = 0; i < BW; i++) bt_run[i] = 0;
      exp_q.delete();
      rd_fire = 1'b0;
    end else begin
      hit  = (memAddress >> 3) == AW'(BASE);
      moff = memAddress[2:0];
      rd_fire = readEnable;
      if (readEnable) exp_q.push_back(hit ? reg_val(moff) : 32'h0);
      m_irq = |(m_pend & m_mask);
      // a bit flips once the twice-delayed input has disagreed DB times running
      for (int i = 0; i < SWW; i++) begin
        if (sw_seen2[i] != m_sw[i]) sw_run[i] = sw_run[i] + 1;
        else sw_run[i] = 0;
        if (sw_run[i] == DB) begin
          m_sw[i] = sw_seen2[i];
          sw_run[i] = 0;
        end
      end
      old_btn = m_btn;
      for (int i = 0; i < BW; i++) begin
        if (bt_seen2[i] != m_btn[i]) bt_run[i] = bt_run[i] + 1;
        else bt_run[i] = 0;
        if (bt_run[i] == DB) begin
          m_btn[i] = bt_seen2[i];
          bt_run[i] = 0;
        end
      end
      sw_seen2 = sw_seen1; sw_seen1 = switches;
      bt_seen2 = bt_seen1; bt_seen1 = btns;
      for (int i = 0; i < BW; i++) begin
`ifdef GPIO_FALLING_EDGE_EN
        if (m_esel[i]) m_set[i] = old_btn[i] && !m_btn[i];
        else m_set[i] = !old_btn[i] && m_btn[i];
`else
        m_set[i] = !old_btn[i] && m_btn[i];
`endif
      end
      m_clr = '0;
      if (writeEnable && hit) begin
        case (moff)
          3'd0: m_led = writeData[LW-1:0];
          3'd3: m_clr = writeData[BW-1:0];
          3'd4: m_mask = writeData[BW-1:0];
`ifdef GPIO_FALLING_EDGE_EN
          3'd5: m_esel = writeData[BW-1:0];
`endif
          default: ;
        endcase
      end
      for (int i = 0; i < BW; i++)
        if (m_set[i]) m_pend[i] = 1'b1;
        else if (m_clr[i]) m_pend[i] = 1'b0;
    end
  end

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  // monitor: readData for each issued read, leds/irq every cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_queue actual=%h required=queued", readData);
        end else begin
          chk("readData", readData, exp_q.pop_front());
        end
      end
      chk("leds", 32'(leds), 32'(m_led));
      chk("irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic cyc(input logic we, input logic re,
                     input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    #1;
    writeEnable = we;
    readEnable  = re;
    memAddress  = a;
    writeData   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, WIN, 32'h0);
  endtask

  task automatic rd(input logic [2:0] o);
    cyc(1'b0, 1'b1, WIN | AW'(o), 32'h0);
  endtask

  task automatic wr(input logic [2:0] o, input logic [31:0] d);
    cyc(1'b1, 1'b0, WIN | AW'(o), d);
  endtask

  logic [AW-1:0] ra;
  int            rr;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_rdata", readData, 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    idle(2);
    rst = 1'b0;
    idle(2);

    wr(3'd0, 32'h0000A5A5);
    idle(1);
    chk("led_write", 32'(leds), 32'h0000A5A5);
    rd(3'd0);
    idle(1);
    chk("led_read", readData, 32'h0000A5A5);

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rdata", readData, 32'h0);
    chk("mid_rst_leds", 32'(leds), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    idle(1);
    rd(3'd0);

    switches = 16'h00F0;
    for (int i = 0; i < 10; i++) rd(3'd1);
    idle(1);
    chk("sw_settled", readData, 32'h000000F0);
    switches = 16'h00F1;
    for (int i = 0; i < 3; i++) rd(3'd1);
    switches = 16'h00F0;
    for (int i = 0; i < 8; i++) rd(3'd1);
    idle(1);
    chk("sw_glitch", readData, 32'h000000F0);

    wr(3'd4, 32'h00000004);
    btns = 16'h0004;
    idle(10);
    rd(3'd3);
    idle(1);
    chk("btn_pend", readData, 32'h00000004);
    chk("btn_irq", 32'(irq), 32'h1);
    wr(3'd3, 32'h00000004);
    idle(2);
    chk("w1c_irq", 32'(irq), 32'h0);
    rd(3'd3);

    btns = 16'h0000;
    idle(8);
    btns = 16'h0004;
    idle(8);
    btns = 16'h0000;
    idle(8);
    btns = 16'h0004;
    idle(4);
    wr(3'd3, 32'h00000004);
    idle(2);
    chk("set_wins_irq", 32'(irq), 32'h1);
    rd(3'd3);
    idle(1);
    chk("set_wins_pend", readData, 32'h00000004);

    wr(3'd0, 32'h00001234);
    cyc(1'b1, 1'b0, AW'(0), 32'h0000FFFF);
    idle(1);
    chk("decode_wr", 32'(leds), 32'h00001234);
    cyc(1'b0, 1'b1, AW'(17 * 8), 32'h0);
    idle(1);
    chk("decode_rd", readData, 32'h0);
    rd(3'd0);
    rd(3'd6);
    idle(1);
    chk("off6_rd", readData, 32'h0);
    wr(3'd1, 32'h00000000);
    rd(3'd1);
    idle(1);
    chk("ro_write", readData, 32'h000000F0);

`ifdef GPIO_FALLING_EDGE_EN
    wr(3'd5, 32'h00000001);
    btns = btns | 16'h0001;
    idle(8);
    rd(3'd3);
    idle(1);
    chk("fall_no_rise", readData & 32'h1, 32'h0);
    btns = btns & 16'hFFFE;
    idle(8);
    rd(3'd3);
    idle(1);
    chk("fall_pend", readData & 32'h1, 32'h1);
`else
    wr(3'd5, 32'h0000FFFF);
    rd(3'd0);
    rd(3'd5);
    idle(1);
    chk("off5_rd", readData, 32'h0);
`endif

    for (int k = 0; k < 800; k++) begin
      rr = int'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) ra = AW'($urandom_range(0, 255));
      else ra = WIN | AW'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) switches = SWW'($urandom);
      if ($urandom_range(0, 5) == 0)
        btns[$urandom_range(0, BW - 1)] ^= 1'b1;
      cyc(rr < 3, rr >= 2 && rr < 7, ra, $urandom);
    end

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
